fwrisc_exec_formal_branch_responder: RTL
========================================

# fwrisc_exec_formal_branch_responder

Execute-side responder for the branch decode/complete handshake used by the exec formal environment. It accepts one decoded branch instruction at a time and evaluates the branch condition. It updates the program counter and acknowledges with a one-cycle `instr_complete`. It lets branch decode stimulus, and the properties written against it, be exercised without the full exec unit.

## Interface
- `RESET_PC`, default 32'h8000_0000: value loaded into `pc` at reset.
- `ENABLE_COMPRESSED`, default 1.
  - 1: 2-byte-aligned targets are legal.
  - 0: `target[1]==1` raises a misaligned exception.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on `clock`.
- `decode_valid`  in  1  decoded instruction present. Held by the sender until the cycle `instr_complete` is seen.
- `instr_c`  in  1  instruction is compressed; fall-through is pc+2, else pc+4.
- `op_type`  in  5  must equal `OP_TYPE_BRANCH` (shared op-type header) for a branch.
- `op_a`, `op_b`  in  32 each  compare operands.
- `op`  in  6  compare op, using the shared ALU-op header: `OP_EQ`, `OP_NE`, `OP_LT`, `OP_GE`, `OP_LTU`, `OP_GEU`.
- `op_c`  in  32  branch offset, already sign-extended.
- `rd`  in  6  ignored; no register write.
- `instr_complete`  out  1  one-cycle completion pulse.
- `pc`  out  32  architectural PC.
- `branch_taken`  out  1  valid while `instr_complete`=1.
- `exception`  out  1  valid while `instr_complete`=1; misaligned target or unsupported op.
- `mtval`  out  32  offending target (misaligned) or 0 (unsupported); held until the next completion.
- `retired_cnt`, `taken_cnt`  out  32 each  saturating event counters.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - When `decode_valid`=1, latch `instr_c`, `op_type`, `op_a`, `op_b`, `op`, `op_c`, then go to EXEC.
  - When `decode_valid`=0, stay in IDLE.
- EXEC, always followed by DONE:
  - Register `cond`:
    - EQ: `a==b`; NE: `a!=b`.
    - LT: signed `a<b`; GE: signed `a>=b`.
    - LTU: unsigned `a<b`; GEU: unsigned `a>=b`.
  - Target = (pc + op_c) mod 2^32, with bit 0 forced to 0.
  - Fall-through = pc + (instr_c ? 2 : 4), mod 2^32.
- DONE: `instr_complete`=1 for exactly one cycle, then go to IDLE.
  - Unsupported op (op_type ≠ `OP_TYPE_BRANCH`, or op not in the list):
    - `exception`=1, `branch_taken`=0, `mtval`=0.
    - pc ← fall-through.
  - cond=0: `branch_taken`=0, pc ← fall-through.
  - cond=1, ENABLE_COMPRESSED=0, target[1]=1:
    - `exception`=1, `branch_taken`=0, `mtval`=target.
    - pc unchanged.
  - cond=1 otherwise: `branch_taken`=1, pc ← target.
  - `retired_cnt` increments on every completion; `taken_cnt` increments when `branch_taken`=1.
  - Both counters stop at 32'hFFFF_FFFF.
- Operands are sampled only on entry to EXEC. Input changes while in EXEC or DONE are ignored.
- Back-to-back instructions: IDLE may accept a new instruction in the cycle right after DONE.
- The sender drops `decode_valid` in the cycle after `instr_complete`, so no instruction is accepted twice.

## Timing
- Reset (`reset`=0 at an edge), from any state including mid-instruction:
  - State → IDLE, `pc`=RESET_PC.
  - `instr_complete`, `branch_taken`, `exception` = 0.
  - `mtval`, `retired_cnt`, `taken_cnt` = 0.
  - An instruction in flight is dropped, not completed.
- Latency:
  - `decode_valid` sampled 1 at edge N (IDLE) → EXEC during cycle N+1 → `instr_complete`=1 during cycle N+2.
  - New `pc` is visible from cycle N+3.
- All outputs are registered; no combinational path from inputs to outputs.
- `pc` changes only at the edge ending a DONE cycle, or at reset.
- Minimum instruction period is 3 cycles.
- `decode_valid` deasserting during EXEC/DONE does not abort the instruction.

## Test plan
- Reset, then EQ with a=b=32'h1234_5678, op_c=16, pc=8000_0000 → completion 2 cycles after accept; taken=1; pc=8000_0010; counters 1/1.
- NE with a=5, b=5, instr_c=1 → taken=0; pc advances by 2; `taken_cnt` unchanged.
- LT with a=FFFF_FFFF, b=0 → taken (signed). LTU with the same operands → not taken, pc+4. GE/GEU as the complements.
- ENABLE_COMPRESSED=0, taken branch with op_c=6 → exception=1; mtval=pc+6; pc unchanged. With ENABLE_COMPRESSED=1 → taken, pc+6.
- Wrap: pc=FFFF_FFFC, op_c=8, taken → pc=0000_0004. op_c=1, taken → target bit 0 cleared.
- Reset asserted during EXEC → no `instr_complete`; pc=RESET_PC. Op_type≠BRANCH → exception=1; mtval=0; pc+4.

Source files
------------

// File: rtl/fwrisc_exec_formal_branch_responder.sv
`default_nettype none
// ============================================================================
// fwrisc_exec_formal_branch_responder: evaluates one decoded branch at a time
// and completes it with a one-cycle pulse.                      Revision: 1.0
// ============================================================================
module fwrisc_exec_formal_branch_responder #(
  parameter logic [31:0] RESET_PC          = 32'h8000_0000,
  parameter bit          ENABLE_COMPRESSED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        decode_valid,
  input  logic        instr_c,
  input  logic [4:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [5:0]  op,
  input  logic [31:0] op_c,
  input  logic [5:0]  rd,
  output logic        instr_complete,
  output logic [31:0] pc,
  output logic        branch_taken,
  output logic        exception,
  output logic [31:0] mtval,
  output logic [31:0] retired_cnt,
  output logic [31:0] taken_cnt
);

  localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
  localparam logic [5:0] OP_EQ  = 6'd5;
  localparam logic [5:0] OP_NE  = 6'd6;
  localparam logic [5:0] OP_LT  = 6'd7;
  localparam logic [5:0] OP_GE  = 6'd8;
  localparam logic [5:0] OP_LTU = 6'd9;
  localparam logic [5:0] OP_GEU = 6'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        instr_c_q, instr_c_d;
  logic [4:0]  op_type_q, op_type_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] op_c_q, op_c_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        instr_complete_q, instr_complete_d;
  logic        branch_taken_q, branch_taken_d;
  logic        exception_q, exception_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  logic        cond;
  logic        op_known;
  logic        supported;
  logic [31:0] target;
  logic [31:0] fall_through;
  logic [5:0]  unused_rd;

  assign unused_rd = rd;

  always_comb begin
    cond     = 1'b0;
    op_known = 1'b1;
    case (op_q)
      OP_EQ:   cond = (op_a_q == op_b_q);
      OP_NE:   cond = (op_a_q != op_b_q);
      OP_LT:   cond = ($signed(op_a_q) <  $signed(op_b_q));
      OP_GE:   cond = ($signed(op_a_q) >= $signed(op_b_q));
      OP_LTU:  cond = (op_a_q <  op_b_q);
      OP_GEU:  cond = (op_a_q >= op_b_q);
      default: op_known = 1'b0;
    endcase
    supported    = op_known && (op_type_q == OP_TYPE_BRANCH);
    target       = (pc_q + op_c_q) & 32'hFFFF_FFFE;
    fall_through = pc_q + (instr_c_q ? 32'd2 : 32'd4);
  end

  always_comb begin
    state_d          = state_q;
    instr_c_d        = instr_c_q;
    op_type_d        = op_type_q;
    op_a_d           = op_a_q;
    op_b_d           = op_b_q;
    op_d             = op_q;
    op_c_d           = op_c_q;
    pc_d             = pc_q;
    pc_next_d        = pc_next_q;
    instr_complete_d = 1'b0;
    branch_taken_d   = 1'b0;
    exception_d      = 1'b0;
    mtval_d          = mtval_q;
    retired_cnt_d    = retired_cnt_q;
    taken_cnt_d      = taken_cnt_q;

    case (state_q)
      IDLE: begin
        if (decode_valid) begin
          instr_c_d = instr_c;
          op_type_d = op_type;
          op_a_d    = op_a;
          op_b_d    = op_b;
          op_d      = op;
          op_c_d    = op_c;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // Outcome is registered here so it is stable for the whole DONE cycle.
        state_d          = DONE;
        instr_complete_d = 1'b1;
        mtval_d          = 32'h0;
        if (retired_cnt_q != 32'hFFFF_FFFF) retired_cnt_d = retired_cnt_q + 32'd1;
        if (!supported) begin
          exception_d = 1'b1;
          pc_next_d   = fall_through;
        end else if (!cond) begin
          pc_next_d   = fall_through;
        end else if (!ENABLE_COMPRESSED && target[1]) begin
          exception_d = 1'b1;
          mtval_d     = target;
          pc_next_d   = pc_q;
        end else begin
          branch_taken_d = 1'b1;
          pc_next_d      = target;
          if (taken_cnt_q != 32'hFFFF_FFFF) taken_cnt_d = taken_cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        pc_d    = pc_next_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= IDLE;
      instr_c_q        <= 1'b0;
      op_type_q        <= 5'h0;
      op_a_q           <= 32'h0;
      op_b_q           <= 32'h0;
      op_q             <= 6'h0;
      op_c_q           <= 32'h0;
      pc_q             <= RESET_PC;
      pc_next_q        <= RESET_PC;
      instr_complete_q <= 1'b0;
      branch_taken_q   <= 1'b0;
      exception_q      <= 1'b0;
      mtval_q          <= 32'h0;
      retired_cnt_q    <= 32'h0;
      taken_cnt_q      <= 32'h0;
    end else begin
      state_q          <= state_d;
      instr_c_q        <= instr_c_d;
      op_type_q        <= op_type_d;
      op_a_q           <= op_a_d;
      op_b_q           <= op_b_d;
      op_q             <= op_d;
      op_c_q           <= op_c_d;
      pc_q             <= pc_d;
      pc_next_q        <= pc_next_d;
      instr_complete_q <= instr_complete_d;
      branch_taken_q   <= branch_taken_d;
      exception_q      <= exception_d;
      mtval_q          <= mtval_d;
      retired_cnt_q    <= retired_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign instr_complete = instr_complete_q;
  assign pc             = pc_q;
  assign branch_taken   = branch_taken_q;
  assign exception      = exception_q;
  assign mtval          = mtval_q;
  assign retired_cnt    = retired_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule
`default_nettype wire
